fake_netlist_bist_ctrl: RTL

Built-in self-test sequencer for one combinational fake-netlist instance (14 primary inputs, 1 primary output). It drives pseudo-random input vectors from an LFSR and waits a programmable settle time per vector. It compacts the netlist output into a 16-bit MISR signature and reports completion, so generated netlists can be compared against golden signatures in simulation or on silicon.

---
 rtl/fake_netlist_bist_ctrl.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/fake_netlist_bist_ctrl.sv
// fake_netlist_bist_ctrl
//
// Built-in self-test sequencer for a single combinational fake-netlist
// instance. A 16-bit Galois LFSR supplies pseudo-random input vectors. Each
// vector is held for SETTLE cycles so the netlist can settle. The netlist
// output is then compacted into a 16-bit MISR (CRC-CCITT polynomial) during a
// one-cycle CAPTURE. When the requested number of vectors has been captured,
// the controller parks in DONE with the signature held for comparison against
// a golden value.
//
// Ports:
//   clk          in   1      rising-edge clock
//   rst          in   1      asynchronous, active-high reset
//   start        in   1      begins a run when sampled high in IDLE or DONE
//   abort        in   1      returns to IDLE from any state; highest priority
//   num_patterns in   CNT_W  vectors to apply, latched on the accepted start
//   dut_in       out  IN_W   vector driven to the netlist (lfsr[IN_W-1:0])
//   dut_out      in   1      netlist primary output
//   busy         out  1      high while in SETTLE or CAPTURE
//   done         out  1      high while in DONE
//   signature    out  16     MISR value
//   pattern_idx  out  CNT_W  vectors captured in the current run

module fake_netlist_bist_ctrl #(
  parameter int unsigned IN_W   = 14,
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned SETTLE = 2,
  parameter logic [15:0] SEED   = 16'hACE1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] num_patterns,
  output logic [IN_W-1:0]  dut_in,
  input  logic             dut_out,
  output logic             busy,
  output logic             done,
  output logic [15:0]      signature,
  output logic [CNT_W-1:0] pattern_idx
);

  // An all-zero seed would lock the LFSR at zero forever.
  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;

  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam logic [15:0] MISR_POLY = 16'h1021;

  // The settle counter only ever needs to hold 0..SETTLE-1.
  localparam int unsigned SC_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SC_W-1:0] SETTLE_LAST = SC_W'(SETTLE - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_CAPTURE,
    ST_DONE
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic [15:0]      lfsr;
  logic [15:0]      misr;
  logic [CNT_W-1:0] idx;
  logic [CNT_W-1:0] count_q;
  logic [SC_W-1:0]  settle_cnt;

  // Control strobes decoded from the current state and inputs.
  logic             idle_or_done;
  logic             load_run;
  logic             load_empty;
  logic             settle_en;
  logic             capture_en;
  logic             settle_last;
  logic             capture_last;

  logic [15:0]      lfsr_nxt;
  logic [15:0]      misr_nxt;

  // --------------------------------------------------------------------------
  // Datapath next-value functions
  // --------------------------------------------------------------------------

  // Right-shifting Galois LFSR.
  always_comb begin
    lfsr_nxt = (lfsr >> 1) ^ (lfsr[0] ? LFSR_TAPS : 16'h0000);
  end

  // Left-shifting MISR with the netlist output folded into bit 0.
  always_comb begin
    misr_nxt = {misr[14:0], 1'b0}
             ^ (misr[15] ? MISR_POLY : 16'h0000)
             ^ {15'b0, dut_out};
  end

  // The comparison is done one bit wider so it stays correct when the latched
  // count is the maximum CNT_W value. The index then stops exactly at the
  // maximum instead of wrapping.
  always_comb begin
    capture_last = (({1'b0, idx} + (CNT_W + 1)'(1)) == {1'b0, count_q});
    settle_last  = (settle_cnt == SETTLE_LAST);
  end

  // --------------------------------------------------------------------------
  // Control decode
  // --------------------------------------------------------------------------

  // abort masks every strobe, so the datapath holds its values on an abort.
  always_comb begin
    idle_or_done = (state == ST_IDLE) || (state == ST_DONE);
    load_run     = !abort && idle_or_done && start && (num_patterns != '0);
    load_empty   = !abort && idle_or_done && start && (num_patterns == '0);
    settle_en    = !abort && (state == ST_SETTLE);
    capture_en   = !abort && (state == ST_CAPTURE);
  end

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_nxt = (num_patterns != '0) ? ST_SETTLE : ST_DONE;
        end
      end
      ST_SETTLE: begin
        if (settle_last) begin
          state_nxt = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        state_nxt = capture_last ? ST_DONE : ST_SETTLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
    if (abort) begin
      state_nxt = ST_IDLE;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: outputs (decoded from the state register only)
  // --------------------------------------------------------------------------

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state)
      ST_SETTLE, ST_CAPTURE: busy = 1'b1;
      ST_DONE:               done = 1'b1;
      default: begin
        busy = 1'b0;
        done = 1'b0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr       <= SEED_EFF;
      misr       <= '0;
      idx        <= '0;
      count_q    <= '0;
      settle_cnt <= '0;
    end else if (abort) begin
      // Keep lfsr/misr/idx for inspection. Only the settle phase is discarded.
      settle_cnt <= '0;
    end else if (load_run) begin
      lfsr       <= SEED_EFF;
      misr       <= '0;
      idx        <= '0;
      count_q    <= num_patterns;
      settle_cnt <= '0;
    end else if (load_empty) begin
      misr       <= '0;
      idx        <= '0;
    end else if (settle_en) begin
      settle_cnt <= settle_last ? '0 : settle_cnt + SC_W'(1);
    end else if (capture_en) begin
      misr       <= misr_nxt;
      lfsr       <= lfsr_nxt;
      idx        <= idx + CNT_W'(1);
    end
  end

  // --------------------------------------------------------------------------
  // Output mapping: every output comes straight from a register
  // --------------------------------------------------------------------------

  assign dut_in      = lfsr[IN_W-1:0];
  assign signature   = misr;
  assign pattern_idx = idx;

endmodule
